// File: rtl/selector_arb_4s1.sv
// Purpose : round-robin arbiter driving the 2-bit select of a shared 4:1 selector path.
// Latency : one cycle from req to grant; handover to the next requester happens with no idle cycle.
// Backpres: a holder keeps the path while its req stays high. It can be forced off only by the hold limit.
//
// Ports:
//   sys_clk    sole clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   req[3:0]   request per requester
//   grant[3:0] one-hot grant, all-zero when idle (registered)
//   sel[1:0]   index of current/last holder (registered)
//   busy       high while a grant is asserted (registered)
//   timeout    one-cycle pulse on a forced release (registered)
//
// Optional feature: define ARB_TIMEOUT_EN to add the per-holder hold limit (MAX_HOLD cycles).
// Without it there is no hold counter, and timeout is held at 0.

module selector_arb_4s1 #(
   parameter int MAX_HOLD = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       busy,
   output logic       timeout
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("selector_arb_4s1: MAX_HOLD must be within 2..255");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [3:0] grant_nxt;
   logic [1:0] sel_nxt;
   logic       busy_nxt;
   logic [1:0] next_start;
   logic [1:0] win;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic       timeout_nxt;
`endif

   // First set request bit scanning start, start+1, ... modulo 4.
   // The scan runs from the farthest offset down, so the nearest hit is the one that remains.
   function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [3:0] r);
      logic [1:0] idx;
      rr_pick = start;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   // Every handover from a holder searches from the slot after that holder.
   assign next_start = sel + 2'd1;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      sel_nxt   = sel;
      busy_nxt  = busy;
      win       = 2'd0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_nxt = hold_cnt;
      timeout_nxt  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (|req) begin
               win       = rr_pick(ptr, req);
               grant_nxt = 4'b0001 << win;
               sel_nxt   = win;
               busy_nxt  = 1'b1;
               state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_nxt = 8'd0;
`endif
            end else begin
               grant_nxt = 4'b0000;
               busy_nxt  = 1'b0;
            end
         end
         GRANT: begin
            // A voluntary release takes priority over the hold limit.
            // Dropping req on the limit edge therefore never pulses timeout.
            if (!req[sel]) begin
               ptr_nxt = next_start;
               if (|req) begin
                  win       = rr_pick(next_start, req);
                  grant_nxt = 4'b0001 << win;
                  sel_nxt   = win;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt_nxt = 8'd0;
`endif
               end else begin
                  grant_nxt = 4'b0000;
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_cnt == HOLD_LAST) begin
               // Forced release. If the holder is the only requester, it wins again from the advanced pointer.
               ptr_nxt      = next_start;
               win          = rr_pick(next_start, req);
               grant_nxt    = 4'b0001 << win;
               sel_nxt      = win;
               timeout_nxt  = 1'b1;
               hold_cnt_nxt = 8'd0;
            end else begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
         ptr   <= 2'd0;
         grant <= 4'b0000;
         sel   <= 2'd0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         grant <= grant_nxt;
         sel   <= sel_nxt;
         busy  <= busy_nxt;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_cnt <= 8'd0;
         timeout  <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
         timeout  <= timeout_nxt;
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: doc/selector_arb_4s1.md
SELECTOR_ARB_4S1 -- requirements
Module: selector_arb_4s1

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per holder when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request; req[i] high = requester i wants the shared 4:1 selector path.
REQ-005 grant  output  4  one-hot grant, or all-zero when idle; registered.
REQ-006 sel  output  2  index of current/last holder; drives the 2-bit select of the 2-bit 4:1 selector; registered.
REQ-007 busy  output  1  high while any grant is asserted; registered.
REQ-008 timeout  output  1  one-cycle pulse on forced release; registered.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (grant=0) and GRANT (exactly one grant bit high).
REQ-010 Round-robin pointer ptr (2 bits) SHALL hold the search start index; the winner is the first set req bit scanning ptr, ptr+1, ... modulo 4.
REQ-011 IDLE: when req != 0 at a rising edge, the block SHALL enter GRANT at that edge with grant=one-hot(winner), sel=winner, busy=1; latency request-to-grant = 1 cycle.
REQ-012 IDLE with req == 0 SHALL keep grant=0, busy=0, sel unchanged.
REQ-013 GRANT: while req[sel]=1 (and no forced release), grant, sel and busy SHALL remain unchanged.
REQ-014 GRANT: when req[sel]=0 at an edge, ptr SHALL become sel+1 mod 4 and, at the same edge, the block SHALL grant the winner from that ptr if any req bit is set (no bubble cycle), else return to IDLE with grant=0, busy=0, sel unchanged.
REQ-015 Changes of req bits other than req[sel] during GRANT SHALL NOT affect the grant.
REQ-016 grant SHALL never have more than one bit set; sel SHALL equal the index of the set grant bit whenever busy=1.
REQ-017 busy SHALL equal the OR of grant bits every cycle.
REQ-018 timeout SHALL be 0 in every cycle except as defined in REQ-023.

Reset
REQ-019 While sys_rst_n=0, grant=4'b0000, sel=2'b00, busy=0, timeout=0, ptr=0, hold counter=0, FSM=IDLE, independent of sys_clk.
REQ-020 Reset asserted mid-grant SHALL drop grant immediately (asynchronously); after deassertion, arbitration SHALL restart from ptr=0 on the first rising edge.

Configuration
REQ-021 Macro ARB_TIMEOUT_EN SHALL compile in the hold-limit logic; without it, no hold counter exists, timeout is tied 0, and a holder keeps the grant indefinitely per REQ-013.
REQ-022 With ARB_TIMEOUT_EN, an 8-bit hold counter SHALL clear on every new grant and increment each cycle in GRANT.
REQ-023 With ARB_TIMEOUT_EN, at the edge where the counter equals MAX_HOLD-1 and req[sel]=1, the block SHALL force release: timeout=1 for one cycle, ptr=sel+1 mod 4, re-grant the winner from that ptr (which is the same holder if it is the only requester), and clear the counter.
REQ-024 A holder dropping req on the same edge the limit is reached SHALL be treated as a normal release per REQ-014 with timeout=0.

Verification
REQ-025 Reset then req=4'b0100 -> one cycle later grant=4'b0100, sel=2, busy=1; req dropped -> next edge grant=0, busy=0, sel=2.
REQ-026 req=4'b1111 held, each holder drops its bit for one cycle after 3 cycles of grant then re-raises -> grant order 0,1,2,3,0 with no idle cycle between grants.
REQ-027 Holder 1 granted, req changes 4'b0010 -> 4'b1011 while req[1] stays high -> grant stays 4'b0010; then req[1]=0 -> next grant 4'b1000 (index 3), not 0.
REQ-028 req=4'b0011 with sys_rst_n pulsed low mid-grant of requester 1 -> grant=0 immediately; after release first grant is requester 0.
REQ-029 ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0101 held constant -> grant alternates 0,2,0 every 4 cycles, timeout pulses on each switch; without macro grant stays 4'b0001 for 100 cycles, timeout=0.
REQ-030 ARB_TIMEOUT_EN, MAX_HOLD=4, only req[3]=1 held -> grant stays 4'b1000, timeout pulses every 4 cycles, busy never drops.
